matrix_mul_sequencer: RTL and testbench

Multi-cycle matrix multiply engine. It computes C = A x B on up to 5x5 matrices of 8-bit elements using one shared multiply-accumulate, one product per cycle. A start/busy/done handshake sequences the work. It sits beside the combinational multiply unit as the low-area alternative and uses the same matrix packing and dimension ports, so the calculator top can select either unit.

---
 rtl/matrix_mul_sequencer_if.sv | 34 +++
 rtl/matrix_mul_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_matrix_mul_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mul_sequencer_if.sv
// Handshake and matrix bus for the sequential matrix multiplier.
// The controller drives start, the dimensions and the operands; the engine drives status and the result.
interface matrix_mul_sequencer_if #(
  parameter int unsigned MAX_DIM = 5,
  parameter int unsigned DW      = 8
);
  localparam int unsigned DIMW = $clog2(MAX_DIM + 1);
  localparam int unsigned BW   = MAX_DIM * MAX_DIM * DW;

  logic            start;
  logic [DIMW-1:0] a_m;
  logic [DIMW-1:0] a_n;
  logic [DIMW-1:0] b_m;
  logic [DIMW-1:0] b_n;
  logic [BW-1:0]   matrixA_in;
  logic [BW-1:0]   matrixB_in;
  logic            busy;
  logic            done;
  logic            error;
  logic            valid;
  logic [DIMW-1:0] c_m;
  logic [DIMW-1:0] c_n;
  logic [BW-1:0]   matrix_out;

  modport master (
    output start, a_m, a_n, b_m, b_n, matrixA_in, matrixB_in,
    input  busy, done, error, valid, c_m, c_n, matrix_out
  );

  modport slave (
    input  start, a_m, a_n, b_m, b_n, matrixA_in, matrixB_in,
    output busy, done, error, valid, c_m, c_n, matrix_out
  );
endinterface

// File: rtl/matrix_mul_sequencer.sv
// Sequential C = A x B engine: one shared multiply-accumulate, one product per cycle,
// sequenced by a start/busy/done handshake.
module matrix_mul_sequencer #(
  parameter int unsigned MAX_DIM = 5,
  parameter int unsigned DW      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  matrix_mul_sequencer_if.slave    bus
);
  localparam int unsigned NEL  = MAX_DIM * MAX_DIM;
  localparam int unsigned IW   = $clog2(NEL);
  localparam int unsigned DIMW = $clog2(MAX_DIM + 1);
  localparam int unsigned BW   = NEL * DW;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    MAC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BW-1:0]   a_lat;
  logic [BW-1:0]   b_lat;
  logic [DIMW-1:0] am_q;
  logic [DIMW-1:0] an_q;
  logic [DIMW-1:0] bm_q;
  logic [DIMW-1:0] bn_q;
  logic [DIMW-1:0] i_q;
  logic [DIMW-1:0] j_q;
  logic [DIMW-1:0] k_q;
  logic [DW-1:0]   acc_q;
  logic [DW-1:0]   acc_nxt;
  logic [DW-1:0]   prod;
  logic [DW-1:0]   a_el [NEL];
  logic [DW-1:0]   b_el [NEL];
  logic [DW-1:0]   c_el [NEL];
  logic [IW-1:0]   a_idx;
  logic [IW-1:0]   b_idx;
  logic [IW-1:0]   c_idx;

  logic            dims_ok;
  logic            err_pend;
  logic            last_k;
  logic            last_j;
  logic            last_i;

  logic            busy_q;
  logic            done_q;
  logic            error_q;
  logic            valid_q;
  logic [DIMW-1:0] cm_q;
  logic [DIMW-1:0] cn_q;

  for (genvar e = 0; e < NEL; e++) begin : g_el
    assign a_el[e] = a_lat[e*DW +: DW];
    assign b_el[e] = b_lat[e*DW +: DW];
    assign bus.matrix_out[e*DW +: DW] = c_el[e];
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.error = error_q;
  assign bus.valid = valid_q;
  assign bus.c_m   = cm_q;
  assign bus.c_n   = cn_q;

  function automatic logic dim_in_range(input logic [DIMW-1:0] d);
    return (d != '0) && (32'(d) <= MAX_DIM);
  endfunction

  always_comb begin
    dims_ok = dim_in_range(am_q) && dim_in_range(an_q) && dim_in_range(bn_q) && (an_q == bm_q);
    a_idx   = IW'(i_q) * IW'(MAX_DIM) + IW'(k_q);
    b_idx   = IW'(k_q) * IW'(MAX_DIM) + IW'(j_q);
    c_idx   = IW'(i_q) * IW'(MAX_DIM) + IW'(j_q);
    prod    = a_el[a_idx] * b_el[b_idx];
    acc_nxt = acc_q + prod;
    last_k  = (k_q == an_q - DIMW'(1));
    last_j  = (j_q == bn_q - DIMW'(1));
    last_i  = (i_q == am_q - DIMW'(1));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = CHECK;
      CHECK:   state_nxt = dims_ok ? MAC : DONE;
      MAC:     if (last_k && last_j && last_i) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Status outputs are registered on leaving DONE, so done/valid/busy=0 appear one
  // edge after the DONE state and coincide with the following IDLE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_lat    <= '0;
      b_lat    <= '0;
      am_q     <= '0;
      an_q     <= '0;
      bm_q     <= '0;
      bn_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      c_el     <= '{default: '0};
      err_pend <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
      cm_q     <= '0;
      cn_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_lat   <= bus.matrixA_in;
            b_lat   <= bus.matrixB_in;
            am_q    <= bus.a_m;
            an_q    <= bus.a_n;
            bm_q    <= bus.b_m;
            bn_q    <= bus.b_n;
            c_el    <= '{default: '0};
            cm_q    <= '0;
            cn_q    <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        CHECK: begin
          err_pend <= !dims_ok;
          i_q      <= '0;
          j_q      <= '0;
          k_q      <= '0;
          acc_q    <= '0;
        end
        MAC: begin
          if (!last_k) begin
            acc_q <= acc_nxt;
            k_q   <= k_q + DIMW'(1);
          end else begin
            c_el[c_idx] <= acc_nxt;
            acc_q       <= '0;
            k_q         <= '0;
            if (!last_j) begin
              j_q <= j_q + DIMW'(1);
            end else begin
              j_q <= '0;
              if (!last_i) i_q <= i_q + DIMW'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          error_q <= err_pend;
          if (!err_pend) begin
            cm_q <= am_q;
            cn_q <= bn_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_mul_sequencer.sv
// Scoreboard bench for matrix_mul_sequencer: stimulus pushes reference-model results,
// a monitor pops and compares them whenever done pulses.
module tb_matrix_mul_sequencer;
  localparam int unsigned MD = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned BW = MD * MD * DW;

  typedef logic [DW-1:0] mat_t [MD][MD];
  typedef struct {
    logic          err;
    logic [2:0]    cm;
    logic [2:0]    cn;
    logic [BW-1:0] mat;
    int unsigned   done_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  matrix_mul_sequencer_if #(.MAX_DIM(MD), .DW(DW)) bus ();
  matrix_mul_sequencer #(.MAX_DIM(MD), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t        sb [$];
  exp_t        mon_e;
  int unsigned cyc     = 0;
  int          n_pass  = 0;
  int          n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [BW-1:0] pack(input mat_t m);
    logic [BW-1:0] v = '0;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        v[(r*MD+c)*DW +: DW] = m[r][c];
    return v;
  endfunction

  // Reference: plain integer dot products, reduced modulo 2^DW at the end.
  function automatic exp_t model(input mat_t A, input mat_t B, input int am, input int an,
                                 input int bm, input int bn, input int unsigned acc_cyc);
    exp_t e;
    int unsigned s;
    e.mat = '0;
    if (am < 1 || am > MD || an < 1 || an > MD || bn < 1 || bn > MD || an != bm) begin
      e.err = 1'b1; e.cm = 3'd0; e.cn = 3'd0; e.done_cyc = acc_cyc + 2;
    end else begin
      e.err = 1'b0; e.cm = 3'(am); e.cn = 3'(bn);
      e.done_cyc = acc_cyc + int'(am * bn * an) + 2;
      for (int r = 0; r < am; r++)
        for (int c = 0; c < bn; c++) begin
          s = 0;
          for (int k = 0; k < an; k++) s += int'(A[r][k]) * int'(B[k][c]);
          e.mat[(r*MD+c)*DW +: DW] = DW'(s % (1 << DW));
        end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending job", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", BW'(cyc), BW'(mon_e.done_cyc));
        check("error", BW'(bus.error), BW'(mon_e.err));
        check("valid", BW'(bus.valid), BW'(1));
        check("busy_at_done", BW'(bus.busy), BW'(0));
        check("c_m", BW'(bus.c_m), BW'(mon_e.cm));
        check("c_n", BW'(bus.c_n), BW'(mon_e.cn));
        check("matrix_out", bus.matrix_out, mon_e.mat);
      end
    end
  end

  task automatic drive(input mat_t A, input mat_t B, input int am, input int an, input int bm, input int bn);
    bus.matrixA_in = pack(A);
    bus.matrixB_in = pack(B);
    bus.a_m = 3'(am); bus.a_n = 3'(an); bus.b_m = 3'(bm); bus.b_n = 3'(bn);
  endtask

  task automatic start_job(input mat_t A, input mat_t B, input int am, input int an,
                           input int bm, input int bn, input bit push);
    @(negedge clk);
    drive(A, B, am, an, bm, bn);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back(model(A, B, am, an, bm, bn, cyc));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns at the negedge where done is seen; flags busy dropping early and timeouts.
  task automatic wait_done(input string name, input int limit);
    int busy_lo = 0;
    for (int t = 0; t < limit; t++) begin
      if (bus.done) begin
        check({name, "_busy_held"}, BW'(busy_lo), BW'(0));
        return;
      end
      if (!bus.busy) busy_lo++;
      @(negedge clk);
    end
    n_total++;
    $display("FAIL %s_timeout: done=0 after %0d cycles, expected done=1", name, limit);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_busy"}, BW'(bus.busy), BW'(0));
    check({name, "_done"}, BW'(bus.done), BW'(0));
    check({name, "_error"}, BW'(bus.error), BW'(0));
    check({name, "_valid"}, BW'(bus.valid), BW'(0));
    check({name, "_c_m"}, BW'(bus.c_m), BW'(0));
    check({name, "_c_n"}, BW'(bus.c_n), BW'(0));
    check({name, "_matrix"}, bus.matrix_out, '0);
  endtask

  function automatic logic [DW-1:0] elem(input logic [BW-1:0] v, input int r, input int c);
    return v[(r*MD+c)*DW +: DW];
  endfunction

  initial begin
    mat_t A, B, Z;
    int am, an, bm, bn;
    logic [BW-1:0] mo;

    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) Z[r][c] = '0;
    bus.start = 1'b0;
    drive(Z, Z, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b1;

    // 2x3 by 3x2
    A = Z; B = Z;
    A[0][0] = 1; A[0][1] = 2; A[0][2] = 3;
    A[1][0] = 3; A[1][1] = 4; A[1][2] = 5;
    B[0][0] = 1; B[0][1] = 0; B[1][0] = 2; B[1][1] = 1; B[2][0] = 3; B[2][1] = 2;
    start_job(A, B, 2, 3, 3, 2, 1'b1);
    wait_done("basic", 40);
    mo = bus.matrix_out;
    check("basic_c00", BW'(elem(mo, 0, 0)), BW'(14));
    check("basic_c01", BW'(elem(mo, 0, 1)), BW'(8));
    check("basic_c10", BW'(elem(mo, 1, 0)), BW'(26));
    check("basic_c11", BW'(elem(mo, 1, 1)), BW'(14));

    // inner dimension mismatch
    start_job(A, B, 2, 3, 2, 2, 1'b1);
    wait_done("mismatch", 10);

    // 5x5 all ones-bits: every element is 5 * (255*255 mod 256) = 5
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin A[r][c] = 8'hFF; B[r][c] = 8'hFF; end
    start_job(A, B, 5, 5, 5, 5, 1'b1);
    wait_done("max5x5", 200);
    mo = bus.matrix_out;
    check("max5x5_c44", BW'(elem(mo, 4, 4)), BW'(5));

    // 1x1 and a zero dimension
    A = Z; B = Z; A[0][0] = 7; B[0][0] = 9;
    start_job(A, B, 1, 1, 1, 1, 1'b1);
    wait_done("one", 10);
    check("one_c00", BW'(elem(bus.matrix_out, 0, 0)), BW'(63));
    start_job(A, B, 0, 1, 1, 1, 1'b1);
    wait_done("zero_dim", 10);

    // start pulsed mid-job with other operands must be ignored
    A = Z; B = Z;
    A[0][0] = 3; A[0][1] = 5; A[1][0] = 7; A[1][1] = 11;
    B[0][0] = 2; B[0][1] = 4; B[1][0] = 6; B[1][1] = 8;
    start_job(A, B, 2, 2, 2, 2, 1'b1);
    repeat (3) @(negedge clk);
    drive(Z, Z, 1, 1, 1, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignored", 40);
    repeat (20) @(negedge clk);
    check("ignored_stays_idle", BW'(bus.busy), BW'(0));

    // start held high: second job accepted in the IDLE cycle after done
    @(negedge clk);
    drive(A, B, 2, 2, 2, 2);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(A, B, 2, 2, 2, 2, cyc));
    @(negedge clk);
    wait_done("b2b_first", 40);
    B[0][0] = 9; B[1][1] = 1;
    drive(A, B, 2, 2, 2, 1);
    @(posedge clk);
    #1;
    sb.push_back(model(A, B, 2, 2, 2, 1, cyc));
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_valid_cleared", BW'(bus.valid), BW'(0));
    check("b2b_busy", BW'(bus.busy), BW'(1));
    wait_done("b2b_second", 40);

    // reset in the middle of a 5x5 job, then a clean rerun
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin A[r][c] = 8'($urandom); B[r][c] = 8'($urandom); end
    start_job(A, B, 5, 5, 5, 5, 1'b0);
    repeat (30) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_cleared("midreset");
    reset = 1'b1;
    start_job(A, B, 5, 5, 5, 5, 1'b1);
    wait_done("after_reset", 200);

    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < MD; r++)
        for (int c = 0; c < MD; c++) begin A[r][c] = 8'($urandom); B[r][c] = 8'($urandom); end
      if ($urandom_range(0, 9) < 7) begin
        am = int'($urandom_range(1, 5)); an = int'($urandom_range(1, 5));
        bn = int'($urandom_range(1, 5)); bm = an;
      end else begin
        am = int'($urandom_range(0, 7)); an = int'($urandom_range(0, 7));
        bm = int'($urandom_range(0, 7)); bn = int'($urandom_range(0, 7));
      end
      start_job(A, B, am, an, bm, bn, 1'b1);
      wait_done("random", 200);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", BW'(sb.size()), BW'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
